// File: rtl/key_input_pkg.sv
// Shared constants for the key input peripheral: bus width, register map and
// the debounce counter sizing helper.
package key_input_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    REG_DATA    = 2'd0,
    REG_RAW     = 2'd1,
    REG_IRQMASK = 2'd2,
    REG_EDGECAP = 2'd3
  } reg_addr_e;

  // A single-cycle debounce still needs a one-bit counter to exist.
  function automatic int cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/key_input_if.sv
// Register-bus interface between a bus master and the key input peripheral.
interface key_input_if;

  logic [1:0]                        address;
  logic                              chipselect;
  logic                              write_n;
  logic [key_input_pkg::DATA_W-1:0]  writedata;
  logic [key_input_pkg::DATA_W-1:0]  readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );

endinterface

// File: rtl/key_debounce.sv
// One key: two-flop synchronizer followed by a stable-level debouncer that
// only accepts a new level after it has persisted for DEBOUNCE_CYCLES clocks.
module key_debounce
  import key_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = cnt_width(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic key_i,
  output logic sync_o,
  output logic stable_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta_q;
  logic             sync_q;
  logic             stable_q;
  logic             stable_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Any cycle where sync agrees with stable restarts the count, so a glitch
  // shorter than the debounce window never accumulates.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync_q != stable_q) begin
      if (cnt_q == LAST) begin
        stable_d = sync_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q   <= 1'b1;
      sync_q   <= 1'b1;
      stable_q <= 1'b1;
      cnt_q    <= '0;
    end else begin
      meta_q   <= key_i;
      sync_q   <= meta_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign sync_o   = sync_q;
  assign stable_o = stable_q;

endmodule

// File: rtl/key_input.sv
// Key input peripheral: debounced active-low keys, press-edge capture with
// write-1-to-clear, interrupt mask and a level interrupt.
module key_input
  import key_input_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             reset,
  key_input_if.slave       bus,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] sync_w;
  logic [WIDTH-1:0] stable_w;
  logic [WIDTH-1:0] stable_dly_q;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] mask_d;
  logic [WIDTH-1:0] edgecap_q;
  logic [WIDTH-1:0] edgecap_d;
  logic             irq_q;
  logic             irq_d;
  logic [WIDTH-1:0] press;
  logic [WIDTH-1:0] clr;
  logic             wr;
  logic [DATA_W-1:0] rdata;
  logic             unused_wdata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk      (clk),
      .reset    (reset),
      .key_i    (in_port[i]),
      .sync_o   (sync_w[i]),
      .stable_o (stable_w[i])
    );
  end

  assign wr    = bus.chipselect & ~bus.write_n;
  assign press = stable_dly_q & ~stable_w;

  // A new press is OR-ed in after the clear so set beats a same-cycle clear.
  always_comb begin
    mask_d = mask_q;
    clr    = '0;
    if (wr && reg_addr_e'(bus.address) == REG_IRQMASK) begin
      mask_d = bus.writedata[WIDTH-1:0];
    end
    if (wr && reg_addr_e'(bus.address) == REG_EDGECAP) begin
      clr = bus.writedata[WIDTH-1:0];
    end
    edgecap_d = (edgecap_q & ~clr) | press;
    irq_d     = |(edgecap_q & mask_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stable_dly_q <= '1;
      mask_q       <= '0;
      edgecap_q    <= '0;
      irq_q        <= 1'b0;
    end else begin
      stable_dly_q <= stable_w;
      mask_q       <= mask_d;
      edgecap_q    <= edgecap_d;
      irq_q        <= irq_d;
    end
  end

  always_comb begin
    rdata = '0;
    case (reg_addr_e'(bus.address))
      REG_DATA:    rdata = DATA_W'(stable_w);
      REG_RAW:     rdata = DATA_W'(sync_w);
      REG_IRQMASK: rdata = DATA_W'(mask_q);
      REG_EDGECAP: rdata = DATA_W'(edgecap_q);
      default:     rdata = '0;
    endcase
  end

  assign bus.readdata = rdata;
  assign irq          = irq_q;
  assign unused_wdata = ^bus.writedata;

endmodule

// File: tb/tb_key_input.sv
// Self-checking bench for key_input: directed vector table, hand-written corner
// sequences and a randomized run against a window-based reference model.
module tb_key_input;
  import key_input_pkg::*;

  localparam int WIDTH = 4;
  localparam int DEB   = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] in_port;
  logic             irq;

  key_input_if bus();

  key_input #(
    .WIDTH(WIDTH),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .in_port (in_port),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    int         n;
    logic [3:0] inPort;
    logic       we;
    logic [1:0] addr;
    logic [3:0] wdata;
    logic [3:0] expData;
    logic [3:0] expRaw;
    logic [3:0] expMask;
    logic [3:0] expEdge;
    logic       expIrq;
  } vec_t;

  vec_t vecs[16];

  // Reference model: a key's debounced level flips once the last DEB
  // synchronized samples all disagree with it.
  logic [3:0] mPin1, mPin2, mStable, mStablePrev, mMask, mEdge;
  logic       mIrq;
  logic [3:0] mWin[$];

  task automatic modelStep();
    logic [3:0] press;
    logic [3:0] clr;
    logic [3:0] nStable;
    logic       allDiff;
    logic       wr;
    if (reset) begin
      mPin1 = '1; mPin2 = '1; mStable = '1; mStablePrev = '1;
      mMask = '0; mEdge = '0; mIrq = 1'b0;
      mWin.delete();
    end else begin
      wr    = bus.chipselect && !bus.write_n;
      press = mStablePrev & ~mStable;
      clr   = (wr && bus.address == 2'd3) ? bus.writedata[3:0] : 4'h0;
      mIrq  = |(mEdge & mMask);
      if (wr && bus.address == 2'd2) mMask = bus.writedata[3:0];
      mEdge = (mEdge & ~clr) | press;
      mWin.push_back(mPin2);
      if (mWin.size() > DEB) void'(mWin.pop_front());
      nStable = mStable;
      for (int i = 0; i < WIDTH; i++) begin
        if (mWin.size() == DEB) begin
          allDiff = 1'b1;
          for (int k = 0; k < DEB; k++) if (mWin[k][i] == mStable[i]) allDiff = 1'b0;
          if (allDiff) nStable[i] = mPin2[i];
        end
      end
      mStablePrev = mStable;
      mStable     = nStable;
      mPin2       = mPin1;
      mPin1       = in_port;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    #1;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic runCycles(input int n);
    for (int c = 0; c < n; c++) tick();
  endtask

  task automatic applyStimulus(input logic [3:0] inPort, input logic we,
                               input logic [1:0] addr, input logic [3:0] wdata);
    in_port        = inPort;
    bus.chipselect = we;
    bus.write_n    = !we;
    bus.address    = addr;
    bus.writedata  = {28'hABCDE12, wdata};
  endtask

  task automatic checkValue(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] eData, input logic [3:0] eRaw,
                             input logic [3:0] eMask, input logic [3:0] eEdge, input logic eIrq);
    logic [3:0] exps[4];
    exps = '{eData, eRaw, eMask, eEdge};
    for (int a = 0; a < 4; a++) begin
      bus.address = 2'(a);
      #1;
      checkValue($sformatf("%s addr%0d", tag, a), bus.readdata, {28'h0, exps[a]});
    end
    checkValue({tag, " irq"}, {31'h0, irq}, {31'h0, eIrq});
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus(4'hF, 1'b0, 2'd0, 4'h0);
    runCycles(2);
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0] pins;
    reset = 1'b1;
    applyStimulus(4'hF, 1'b0, 2'd0, 4'h0);

    //            n  in    we    addr  wd    DATA  RAW   MASK  EDGE  IRQ
    vecs[0]  = '{2, 4'hE, 1'b0, 2'd0, 4'h0, 4'hF, 4'hE, 4'h0, 4'h0, 1'b0};
    vecs[1]  = '{3, 4'hE, 1'b0, 2'd0, 4'h0, 4'hF, 4'hE, 4'h0, 4'h0, 1'b0};
    vecs[2]  = '{1, 4'hE, 1'b0, 2'd0, 4'h0, 4'hE, 4'hE, 4'h0, 4'h0, 1'b0};
    vecs[3]  = '{1, 4'hE, 1'b0, 2'd0, 4'h0, 4'hE, 4'hE, 4'h0, 4'h1, 1'b0};
    vecs[4]  = '{1, 4'hE, 1'b0, 2'd0, 4'h0, 4'hE, 4'hE, 4'h0, 4'h1, 1'b0};
    vecs[5]  = '{1, 4'hE, 1'b1, 2'd3, 4'h1, 4'hE, 4'hE, 4'h0, 4'h0, 1'b0};
    vecs[6]  = '{1, 4'hF, 1'b1, 2'd2, 4'h1, 4'hE, 4'hE, 4'h1, 4'h0, 1'b0};
    vecs[7]  = '{1, 4'hF, 1'b0, 2'd0, 4'h0, 4'hE, 4'hF, 4'h1, 4'h0, 1'b0};
    vecs[8]  = '{4, 4'hF, 1'b0, 2'd0, 4'h0, 4'hF, 4'hF, 4'h1, 4'h0, 1'b0};
    vecs[9]  = '{1, 4'hF, 1'b0, 2'd0, 4'h0, 4'hF, 4'hF, 4'h1, 4'h0, 1'b0};
    vecs[10] = '{2, 4'hE, 1'b0, 2'd0, 4'h0, 4'hF, 4'hE, 4'h1, 4'h0, 1'b0};
    vecs[11] = '{4, 4'hE, 1'b0, 2'd0, 4'h0, 4'hE, 4'hE, 4'h1, 4'h0, 1'b0};
    vecs[12] = '{1, 4'hE, 1'b0, 2'd0, 4'h0, 4'hE, 4'hE, 4'h1, 4'h1, 1'b0};
    vecs[13] = '{1, 4'hE, 1'b0, 2'd0, 4'h0, 4'hE, 4'hE, 4'h1, 4'h1, 1'b1};
    vecs[14] = '{1, 4'hE, 1'b1, 2'd3, 4'h1, 4'hE, 4'hE, 4'h1, 4'h0, 1'b1};
    vecs[15] = '{1, 4'hE, 1'b0, 2'd0, 4'h0, 4'hE, 4'hE, 4'h1, 4'h0, 1'b0};

    doReset();
    checkOutput("reset", 4'hF, 4'hF, 4'h0, 4'h0, 1'b0);

    for (int v = 0; v < 16; v++) begin
      applyStimulus(vecs[v].inPort, vecs[v].we, vecs[v].addr, vecs[v].wdata);
      runCycles(vecs[v].n);
      checkOutput($sformatf("vec%0d", v), vecs[v].expData, vecs[v].expRaw,
                  vecs[v].expMask, vecs[v].expEdge, vecs[v].expIrq);
    end

    // Two short glitches back to back must not add up to a debounce.
    doReset();
    applyStimulus(4'hD, 1'b0, 2'd0, 4'h0);
    runCycles(2);
    in_port = 4'hF;
    runCycles(3);
    checkOutput("glitch mid", 4'hF, 4'hF, 4'h0, 4'h0, 1'b0);
    in_port = 4'hD;
    runCycles(2);
    in_port = 4'hF;
    runCycles(8);
    checkOutput("glitch end", 4'hF, 4'hF, 4'h0, 4'h0, 1'b0);

    // Press capture coinciding with a write-1-clear of the same bit.
    doReset();
    applyStimulus(4'hB, 1'b0, 2'd0, 4'h0);
    runCycles(6);
    checkOutput("k2 debounced", 4'hB, 4'hB, 4'h0, 4'h0, 1'b0);
    applyStimulus(4'hB, 1'b1, 2'd3, 4'h4);
    runCycles(1);
    checkOutput("k2 set wins", 4'hB, 4'hB, 4'h0, 4'h4, 1'b0);
    applyStimulus(4'hB, 1'b1, 2'd3, 4'h4);
    runCycles(1);
    checkOutput("k2 cleared", 4'hB, 4'hB, 4'h0, 4'h0, 1'b0);

    // Simultaneous presses, release, then reset in the middle of a debounce.
    doReset();
    applyStimulus(4'h6, 1'b0, 2'd0, 4'h0);
    runCycles(6);
    checkOutput("k03 debounced", 4'h6, 4'h6, 4'h0, 4'h0, 1'b0);
    runCycles(1);
    checkOutput("k03 edge", 4'h6, 4'h6, 4'h0, 4'h9, 1'b0);
    applyStimulus(4'hF, 1'b0, 2'd0, 4'h0);
    runCycles(8);
    checkOutput("k03 released", 4'hF, 4'hF, 4'h0, 4'h9, 1'b0);
    applyStimulus(4'hF, 1'b1, 2'd2, 4'hF);
    runCycles(1);
    checkOutput("mask written", 4'hF, 4'hF, 4'hF, 4'h9, 1'b0);
    runCycles(1);
    checkOutput("irq raised", 4'hF, 4'hF, 4'hF, 4'h9, 1'b1);
    applyStimulus(4'hE, 1'b0, 2'd0, 4'h0);
    runCycles(4);
    checkOutput("mid debounce", 4'hF, 4'hE, 4'hF, 4'h9, 1'b1);
    reset = 1'b1;
    applyStimulus(4'hE, 1'b1, 2'd2, 4'hF);
    runCycles(1);
    reset = 1'b0;
    checkOutput("reset override", 4'hF, 4'hF, 4'h0, 4'h0, 1'b0);
    runCycles(6);
    checkOutput("post reset debounced", 4'hE, 4'hE, 4'h0, 4'h0, 1'b0);
    runCycles(1);
    checkOutput("post reset edge", 4'hE, 4'hE, 4'h0, 4'h1, 1'b0);
    runCycles(3);
    checkOutput("post reset single", 4'hE, 4'hE, 4'h0, 4'h1, 1'b0);

    // Randomized traffic against the reference model.
    doReset();
    pins = 4'hF;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < WIDTH; i++) if ($urandom_range(0, 5) == 0) pins[i] = ~pins[i];
      reset = ($urandom_range(0, 299) == 0);
      applyStimulus(pins, ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
                    4'($urandom_range(0, 15)));
      bus.write_n = bus.chipselect ? 1'($urandom_range(0, 1)) : 1'b1;
      runCycles(1);
      reset = 1'b0;
      checkOutput("rand", mStable, mPin2, mMask, mEdge, mIrq);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
